gmii_tx_arbiter: RTL
====================

// Module: gmii_tx_arbiter
// PURPOSE
//  Shares one GMII transmit path between two frame sources: port 0 (time-sensitive)
//  and port 1 (best-effort). Sits upstream of the GMII TX CRC/output stage and drives
//  its ppt2gtc_gmii_* inputs.
//  Grants one source per frame and forwards its GMII bytes. Holds a post-frame gap that
//  covers the 4 CRC bytes appended downstream plus the inter-frame gap. Truncates
//  runaway frames.
// PARAMETERS
//  GAP_CYCLES      16    idle cycles after dv falls (4 CRC bytes + 12 IFG); legal range 1..255
//  MAX_FRAME       1530  max dv-high cycles per frame, preamble included; legal range 64..4095
//  START_TIMEOUT   32    cycles a grant waits for the source's dv before the grant is revoked
// PORTS
//  clk             in   1   system clock (GMII 125 MHz)
//  rst             in   1   asynchronous, active-high reset
//  req0            in   1   port 0 has a frame ready; level signal, held until granted
//  grant0          out  1   port 0 owns the path
//  gmii_dv0        in   1   port 0 data valid
//  gmii_er0        in   1   port 0 error
//  gmii_data0      in   8   port 0 byte (preamble, SFD, payload; no FCS)
//  req1/grant1/gmii_dv1/gmii_er1/gmii_data1   same as port 0, for port 1
//  ppt2gtc_gmii_dv   out 1  forwarded data valid
//  ppt2gtc_gmii_er   out 1  forwarded error
//  ppt2gtc_gmii_data out 8  forwarded byte
//  trunc_cnt       out  16  number of truncated frames; saturates at 16'hFFFF
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, gap/byte/timeout counters 0, rr_last=1 (port 0 wins first).
//  All outputs are registered. Datapath latency = 1 clk from gmii_*N to ppt2gtc_*.
//  FSM states:
//   IDLE: if any req is high, arbitrate, set grantN=1 (registered), go to GRANT. Forwarded outputs = 0.
//   GRANT: dv of the granted port = 1 -> go to XMIT and forward that byte.
//          Timeout counter reaches START_TIMEOUT -> clear grant, go to IDLE (no gap), set rr_last to
//          the revoked port.
//   XMIT: forward the granted port's dv/er/data each cycle. The byte counter increments while dv=1.
//     - dv falls -> forwarded dv=0, grant=0, load gap counter with GAP_CYCLES, go to GAP.
//     - byte counter == MAX_FRAME with dv still 1 -> output one cycle of dv=1, er=1, data=8'h00,
//       then dv=0, grant=0, trunc_cnt+1, go to GAP.
//   GAP: forwarded outputs = 0, gap counter decrements to 0. Exit to IDLE only when the counter
//        is 0 AND the previously granted port's dv is 0. Otherwise stay in GAP (drains a truncated
//        source).
//  The ungranted port's gmii_* inputs are ignored at all times.
//  A req that drops while in GRANT is ignored. Only dv or the timeout ends GRANT.
//  Simultaneous req0 and req1 in IDLE: resolved by the arbitration policy (see CONFIGURATION).
//  A req arriving during XMIT or GAP waits. It is not dropped; it is arbitrated on IDLE entry.
//  Back-to-back frames: the minimum spacing between forwarded dv-low and the next dv-high is
//  GAP_CYCLES + 2 cycles (IDLE + grant registration).
//  rst asserted mid-frame: outputs drop to 0 asynchronously and the partial frame is abandoned.
//  Sources must restart on grant.
// CONFIGURATION
//  GMII_TX_ARB_RR_EN defined: round-robin. On a tie, the port != rr_last wins. rr_last updates on
//    every grant end (frame, truncation or timeout).
//  Not defined: strict priority. Port 0 wins every tie. Port 1 is granted only when req0=0 in IDLE.
//    rr_last logic is not compiled.
// TESTING
//  T1 port 0 only, 64B frame (8B preamble+SFD): grant0 1 clk after req0; ppt2gtc mirrors the
//     input 1 clk late, 72 dv cycles; then 16 idle cycles.
//  T2 req0 and req1 high together, strict mode: port 0 is sent first. Port 1 dv rises no earlier
//     than 18 clks after port 0 dv falls.
//  T3 same stimulus with GMII_TX_ARB_RR_EN: port 0 then port 1. Re-request both: port 0 again
//     (rr_last=1).
//  T4 port 1 holds dv for 2000 cycles: forwarded dv lasts 1530 cycles, then 1 cycle er=1, then
//     dv=0; trunc_cnt=1. IDLE is not entered until dv1 drops.
//  T5 grant0 issued, port 0 never raises dv: grant0 drops after 32 cycles. A pending req1 is
//     granted next with no gap.
//  T6 rst pulsed during XMIT at byte 30: all outputs 0 the same cycle. A new req0 afterwards
//     is granted normally.

Source files
------------

// File: rtl/gmii_tx_arbiter.sv
// gmii_tx_arbiter
// Shares one GMII transmit path between a time-sensitive source (port 0) and a
// best-effort source (port 1), feeding the downstream TX CRC/output stage.
// One source is granted per frame and its bytes are forwarded one cycle late.
// After each frame a gap covers the appended CRC bytes plus the inter-frame gap.
// Frames longer than MAX_FRAME are cut with a one-cycle error marker.
// Build option: define GMII_TX_ARB_RR_EN for round-robin tie breaking; without
// it port 0 has strict priority.

module gmii_tx_arbiter #(
   parameter int GAP_CYCLES    = 16,
   parameter int MAX_FRAME     = 1530,
   parameter int START_TIMEOUT = 32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req0,
   output logic        grant0,
   input  logic        gmii_dv0,
   input  logic        gmii_er0,
   input  logic [7:0]  gmii_data0,
   input  logic        req1,
   output logic        grant1,
   input  logic        gmii_dv1,
   input  logic        gmii_er1,
   input  logic [7:0]  gmii_data1,
   output logic        ppt2gtc_gmii_dv,
   output logic        ppt2gtc_gmii_er,
   output logic [7:0]  ppt2gtc_gmii_data,
   output logic [15:0] trunc_cnt
);

   localparam int TW = (START_TIMEOUT > 1) ? $clog2(START_TIMEOUT) : 1;
   localparam logic [TW-1:0] TMO_LAST    = TW'(START_TIMEOUT - 1);
   localparam logic [7:0]    GAP_LOAD    = 8'(GAP_CYCLES);
   localparam logic [12:0]   FRAME_LIMIT = 13'(MAX_FRAME);

   typedef enum logic [1:0] {IDLE, GRANT, XMIT, GAP} state_t;

   state_t         state, state_nxt;
   logic           sel, sel_nxt;
   logic           win;
   logic [7:0]     gap_cnt, gap_nxt, gap_dec;
   logic [12:0]    byte_cnt, byte_nxt;
   logic [TW-1:0]  tmo_cnt, tmo_nxt;
   logic           grant0_nxt, grant1_nxt;
   logic           dv_nxt, er_nxt;
   logic [7:0]     data_nxt;
   logic [15:0]    trunc_nxt;
   logic           src_dv, src_er;
   logic [7:0]     src_data;

   // The owning source's GMII signals; the other port is never looked at
   assign src_dv   = sel ? gmii_dv1   : gmii_dv0;
   assign src_er   = sel ? gmii_er1   : gmii_er0;
   assign src_data = sel ? gmii_data1 : gmii_data0;

   // Gap counter value after this cycle, floored at zero while draining a source
   assign gap_dec = (gap_cnt != 8'd0) ? gap_cnt - 8'd1 : 8'd0;

`ifdef GMII_TX_ARB_RR_EN
   logic rr_last, rr_nxt;

   // On a tie the port that did not own the previous grant wins
   assign win = (req0 && req1) ? ~rr_last : req1;

   // Remembers which port owned the most recently ended grant
   always_ff @(posedge clk or posedge rst) begin
      if (rst) rr_last <= 1'b1;
      else     rr_last <= rr_nxt;
   end
`else
   // Port 0 wins whenever it is requesting
   assign win = ~req0;
`endif

   // Next-state and next-output decode for the grant/forward/gap sequence
   always_comb begin
      state_nxt  = state;
      sel_nxt    = sel;
      gap_nxt    = gap_cnt;
      byte_nxt   = byte_cnt;
      tmo_nxt    = tmo_cnt;
      grant0_nxt = grant0;
      grant1_nxt = grant1;
      dv_nxt     = 1'b0;
      er_nxt     = 1'b0;
      data_nxt   = 8'h00;
      trunc_nxt  = trunc_cnt;
`ifdef GMII_TX_ARB_RR_EN
      rr_nxt     = rr_last;
`endif
      case (state)
         IDLE: begin
            if (req0 || req1) begin
               sel_nxt    = win;
               grant0_nxt = ~win;
               grant1_nxt = win;
               tmo_nxt    = '0;
               state_nxt  = GRANT;
            end
         end
         GRANT: begin
            if (src_dv) begin
               dv_nxt    = 1'b1;
               er_nxt    = src_er;
               data_nxt  = src_data;
               byte_nxt  = 13'd1;
               state_nxt = XMIT;
            end else if (tmo_cnt == TMO_LAST) begin
               grant0_nxt = 1'b0;
               grant1_nxt = 1'b0;
               tmo_nxt    = '0;
               state_nxt  = IDLE;
`ifdef GMII_TX_ARB_RR_EN
               rr_nxt     = sel;
`endif
            end else begin
               tmo_nxt = tmo_cnt + 1'b1;
            end
         end
         XMIT: begin
            if (byte_cnt > FRAME_LIMIT) begin
               grant0_nxt = 1'b0;
               grant1_nxt = 1'b0;
               gap_nxt    = GAP_LOAD;
               trunc_nxt  = (trunc_cnt != 16'hFFFF) ? trunc_cnt + 16'd1 : trunc_cnt;
               state_nxt  = GAP;
`ifdef GMII_TX_ARB_RR_EN
               rr_nxt     = sel;
`endif
            end else if (!src_dv) begin
               grant0_nxt = 1'b0;
               grant1_nxt = 1'b0;
               gap_nxt    = GAP_LOAD;
               state_nxt  = GAP;
`ifdef GMII_TX_ARB_RR_EN
               rr_nxt     = sel;
`endif
            end else if (byte_cnt == FRAME_LIMIT) begin
               dv_nxt   = 1'b1;
               er_nxt   = 1'b1;
               data_nxt = 8'h00;
               byte_nxt = byte_cnt + 13'd1;
            end else begin
               dv_nxt   = 1'b1;
               er_nxt   = src_er;
               data_nxt = src_data;
               byte_nxt = byte_cnt + 13'd1;
            end
         end
         GAP: begin
            gap_nxt = gap_dec;
            if ((gap_dec == 8'd0) && !src_dv) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State, counters and all outputs are registered
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state             <= IDLE;
         sel               <= 1'b0;
         gap_cnt           <= 8'd0;
         byte_cnt          <= 13'd0;
         tmo_cnt           <= '0;
         grant0            <= 1'b0;
         grant1            <= 1'b0;
         ppt2gtc_gmii_dv   <= 1'b0;
         ppt2gtc_gmii_er   <= 1'b0;
         ppt2gtc_gmii_data <= 8'h00;
         trunc_cnt         <= 16'd0;
      end else begin
         state             <= state_nxt;
         sel               <= sel_nxt;
         gap_cnt           <= gap_nxt;
         byte_cnt          <= byte_nxt;
         tmo_cnt           <= tmo_nxt;
         grant0            <= grant0_nxt;
         grant1            <= grant1_nxt;
         ppt2gtc_gmii_dv   <= dv_nxt;
         ppt2gtc_gmii_er   <= er_nxt;
         ppt2gtc_gmii_data <= data_nxt;
         trunc_cnt         <= trunc_nxt;
      end
   end

endmodule
